glyph_update_scheduler: RTL and testbench

- Owns the 6-entry glyph-code table that the character painter reads: one code per on-screen character position (slot index = painter's 3-bit character enable).
- Arbitrates table writes between two requesters:
  - RTC readout path (time/date digits).
  - User edit path (switch/button editing).
- Stages writes in a shadow table and commits them to the live table only at vertical-blank start, so no frame ever tears.
- Generates the edit-cursor blink by blanking one slot on alternate blink periods.

---
 rtl/glyph_update_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_glyph_update_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_update_scheduler.sv
// Glyph-code table for the character painter: arbitrated RTC/user writes staged in a
// shadow table, committed slot-by-slot at vblank start; also drives the cursor blink.
module glyph_update_scheduler #(
  parameter int SLOTS        = 6,
  parameter int CODE_W       = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              rtc_req,
  input  logic [2:0]        rtc_slot,
  input  logic [CODE_W-1:0] rtc_code,
  output logic              rtc_ack,
  input  logic              usr_req,
  input  logic [2:0]        usr_slot,
  input  logic [CODE_W-1:0] usr_code,
  output logic              usr_ack,
  input  logic              cursor_en,
  input  logic [2:0]        cursor_slot,
  input  logic [2:0]        rd_slot,
  output logic [CODE_W-1:0] rd_code,
  output logic              rd_visible,
  output logic              commit_done,
  output logic              err_slot
);

  localparam int BW = $clog2(BLINK_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [2:0]                   idx_q, idx_d;
  logic [SLOTS-1:0][CODE_W-1:0] live_q, live_d;
  logic [SLOTS-1:0][CODE_W-1:0] shadow_q, shadow_d;
  logic [SLOTS-1:0]             pend_q, pend_d;
  logic                         vblank_q, vblank_d;
  logic [BW-1:0]                blink_cnt_q, blink_cnt_d;
  logic                         blink_phase_q, blink_phase_d;
  logic                         rr_usr_q, rr_usr_d;
  logic                         rtc_ack_q, rtc_ack_d;
  logic                         usr_ack_q, usr_ack_d;
  logic                         commit_done_q, commit_done_d;
  logic                         err_slot_q, err_slot_d;

  logic                         vblank_rise;
  logic                         rtc_vld, usr_vld;
  logic                         grant_rtc, grant_usr;
  logic [2:0]                   wr_slot;
  logic [CODE_W-1:0]            wr_code;

  assign vblank_rise = vblank && !vblank_q;

  // A requester is masked while its ack is out so a held req is not taken twice.
  assign rtc_vld   = rtc_req && !rtc_ack_q;
  assign usr_vld   = usr_req && !usr_ack_q;
  assign grant_rtc = rtc_vld && (!usr_vld || !rr_usr_q);
  assign grant_usr = usr_vld && !grant_rtc;
  assign wr_slot   = grant_rtc ? rtc_slot : usr_slot;
  assign wr_code   = grant_rtc ? rtc_code : usr_code;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    live_d        = live_q;
    shadow_d      = shadow_q;
    pend_d        = pend_q;
    vblank_d      = vblank;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    rr_usr_d      = rr_usr_q;
    rtc_ack_d     = 1'b0;
    usr_ack_d     = 1'b0;
    commit_done_d = 1'b0;
    err_slot_d    = 1'b0;

    if (vblank_rise) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // A vblank edge takes priority; any request in that cycle waits for IDLE again.
        if (vblank_rise) begin
          state_d = COMMIT;
          idx_d   = '0;
        end else if (grant_rtc || grant_usr) begin
          rtc_ack_d = grant_rtc;
          usr_ack_d = grant_usr;
          if (rtc_vld && usr_vld) begin
            rr_usr_d = grant_rtc;
          end
          if ({1'b0, wr_slot} < 4'(SLOTS)) begin
            for (int i = 0; i < SLOTS; i++) begin
              if (wr_slot == 3'(i)) begin
                shadow_d[i] = wr_code;
                pend_d[i]   = 1'b1;
              end
            end
          end else begin
            err_slot_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        for (int i = 0; i < SLOTS; i++) begin
          if (idx_q == 3'(i) && pend_q[i]) begin
            live_d[i] = shadow_q[i];
            pend_d[i] = 1'b0;
          end
        end
        if (idx_q == 3'(SLOTS - 1)) begin
          state_d       = DONE;
          commit_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      live_q        <= '0;
      shadow_q      <= '0;
      pend_q        <= '0;
      vblank_q      <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      rr_usr_q      <= 1'b0;
      rtc_ack_q     <= 1'b0;
      usr_ack_q     <= 1'b0;
      commit_done_q <= 1'b0;
      err_slot_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      live_q        <= live_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      vblank_q      <= vblank_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      rr_usr_q      <= rr_usr_d;
      rtc_ack_q     <= rtc_ack_d;
      usr_ack_q     <= usr_ack_d;
      commit_done_q <= commit_done_d;
      err_slot_q    <= err_slot_d;
    end
  end

  assign rtc_ack     = rtc_ack_q;
  assign usr_ack     = usr_ack_q;
  assign commit_done = commit_done_q;
  assign err_slot    = err_slot_q;

  // Painter read port: out-of-range slots read as a dark blank.
  always_comb begin
    rd_code    = '0;
    rd_visible = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (rd_slot == 3'(i)) begin
        rd_code    = live_q[i];
        rd_visible = !(cursor_en && (cursor_slot == rd_slot) && blink_phase_q);
      end
    end
  end

endmodule

// File: tb/tb_glyph_update_scheduler.sv
// Bench for glyph_update_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a time-based behavioural model of the table and arbiter.
module tb_glyph_update_scheduler;
  localparam int SLOTS  = 6;
  localparam int CODE_W = 4;
  localparam int BF     = 2;

  logic              clk;
  logic              rst_n;
  logic              vblank;
  logic              rtc_req, usr_req;
  logic [2:0]        rtc_slot, usr_slot;
  logic [CODE_W-1:0] rtc_code, usr_code;
  logic              rtc_ack, usr_ack;
  logic              cursor_en;
  logic [2:0]        cursor_slot, rd_slot;
  logic [CODE_W-1:0] rd_code;
  logic              rd_visible, commit_done, err_slot;

  int checks   = 0;
  int failures = 0;

  glyph_update_scheduler #(.SLOTS(SLOTS), .CODE_W(CODE_W), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank),
    .rtc_req(rtc_req), .rtc_slot(rtc_slot), .rtc_code(rtc_code), .rtc_ack(rtc_ack),
    .usr_req(usr_req), .usr_slot(usr_slot), .usr_code(usr_code), .usr_ack(usr_ack),
    .cursor_en(cursor_en), .cursor_slot(cursor_slot),
    .rd_slot(rd_slot), .rd_code(rd_code), .rd_visible(rd_visible),
    .commit_done(commit_done), .err_slot(err_slot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timing is tracked as cycle numbers: a commit started by the edge sampled in cycle E
  // occupies cycles E+1..E+SLOTS (slot k in cycle E+1+k) and reports done in E+SLOTS+1.
  int m_live[8];
  int m_shadow[8];
  bit m_pend[8];
  int m_cyc, m_edge, m_frames;
  bit m_prev_vb, m_turn_usr;
  bit e_rack, e_uack, e_err, e_done;

  bit s_rst, s_vb, s_rreq, s_ureq;
  int s_rslot, s_rcode, s_uslot, s_ucode;

  function automatic int when_in(input int c, input int edge_c);
    int d;
    d = c - edge_c;
    if (d >= 1 && d <= SLOTS) return 1;
    if (d == SLOTS + 1) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_live[i] = 0; m_shadow[i] = 0; m_pend[i] = 1'b0;
    end
    m_cyc = 0; m_edge = -1000; m_frames = 0;
    m_prev_vb = 1'b0; m_turn_usr = 1'b0;
    e_rack = 1'b0; e_uack = 1'b0; e_err = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_step();
    int ph, k, slot, code;
    bit rise, rv, uv, g_usr;
    ph   = when_in(m_cyc, m_edge);
    rise = s_vb && !m_prev_vb;
    m_prev_vb = s_vb;
    if (rise) m_frames++;
    rv = s_rreq && !e_rack;
    uv = s_ureq && !e_uack;
    e_rack = 1'b0; e_uack = 1'b0; e_err = 1'b0;
    if (ph == 1) begin
      k = m_cyc - m_edge - 1;
      if (m_pend[k]) begin
        m_live[k] = m_shadow[k];
        m_pend[k] = 1'b0;
      end
    end else if (ph == 0) begin
      if (rise) begin
        m_edge = m_cyc;
      end else if (rv || uv) begin
        if (rv && uv) begin
          g_usr = m_turn_usr;
          m_turn_usr = !g_usr;
        end else begin
          g_usr = uv;
        end
        slot = g_usr ? s_uslot : s_rslot;
        code = g_usr ? s_ucode : s_rcode;
        if (g_usr) e_uack = 1'b1; else e_rack = 1'b1;
        if (slot < SLOTS) begin
          m_shadow[slot] = code;
          m_pend[slot]   = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end
    end
    m_cyc++;
    e_done = (when_in(m_cyc, m_edge) == 2);
  endtask

  // Compare process: checks every cycle, 1 time unit after the active edge.
  initial begin
    int rs, exp_code, exp_vis;
    bit phase;
    model_reset();
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_vb = vblank;
      s_rreq = rtc_req; s_rslot = int'(rtc_slot); s_rcode = int'(rtc_code);
      s_ureq = usr_req; s_uslot = int'(usr_slot); s_ucode = int'(usr_code);
      #1;
      if (!s_rst) model_reset(); else model_step();
      chk("rtc_ack", int'(rtc_ack), int'(e_rack));
      chk("usr_ack", int'(usr_ack), int'(e_uack));
      chk("err_slot", int'(err_slot), int'(e_err));
      chk("commit_done", int'(commit_done), int'(e_done));
      rs    = int'(rd_slot);
      phase = ((m_frames / BF) % 2) == 1;
      exp_code = (rs < SLOTS) ? m_live[rs] : 0;
      exp_vis  = (rs < SLOTS) ? int'(!(cursor_en && cursor_slot == rd_slot && phase)) : 0;
      chk("rd_code", int'(rd_code), exp_code);
      chk("rd_visible", int'(rd_visible), exp_vis);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_step();
    @(negedge clk);
    if (rtc_ack) rtc_req = 1'b0;
    if (usr_ack) usr_req = 1'b0;
  endtask

  task automatic do_commit();
    cyc_step();
    vblank = 1'b1;
    cyc_step();
    vblank = 1'b0;
    repeat (8) cyc_step();
  endtask

  task automatic do_reset();
    cyc_step();
    rst_n = 1'b0;
    repeat (2) cyc_step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vb_hold;
    bit done_seen;
    rst_n = 1'b0; vblank = 1'b0;
    rtc_req = 1'b0; rtc_slot = '0; rtc_code = '0;
    usr_req = 1'b0; usr_slot = '0; usr_code = '0;
    cursor_en = 1'b0; cursor_slot = '0; rd_slot = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state of the read port
    for (int s = 0; s < 8; s++) begin
      cyc_step();
      rd_slot = 3'(s);
      #1;
      chk("t1_rd_code", int'(rd_code), 0);
      chk("t1_rd_visible", int'(rd_visible), (s < SLOTS) ? 1 : 0);
    end

    // Single RTC write to slot 2, then commit timing
    cyc_step();
    rtc_req = 1'b1; rtc_slot = 3'd2; rtc_code = 4'd9; rd_slot = 3'd2;
    cyc_step();
    chk("t2_ack", int'(rtc_ack), 1);
    cyc_step();
    chk("t2_ack_once", int'(rtc_ack), 0);
    chk("t2_live_old", int'(rd_code), 0);
    vblank = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc_step();
      if (k == 0) vblank = 1'b0;
      chk("t2_rd_code_k", int'(rd_code), (k >= 3) ? 9 : 0);
      chk("t2_commit_done_k", int'(commit_done), (k == SLOTS) ? 1 : 0);
    end

    // Contention on slot 4: RTC first, user second, user value committed
    cyc_step();
    rtc_req = 1'b1; rtc_slot = 3'd4; rtc_code = 4'd3;
    usr_req = 1'b1; usr_slot = 3'd4; usr_code = 4'd7; rd_slot = 3'd4;
    cyc_step();
    chk("t3_rtc_first", int'(rtc_ack), 1);
    chk("t3_usr_wait", int'(usr_ack), 0);
    cyc_step();
    chk("t3_usr_second", int'(usr_ack), 1);
    chk("t3_rtc_no_dup", int'(rtc_ack), 0);
    do_commit();
    chk("t3_slot4", int'(rd_code), 7);
    // Second contention: pointer now favours the user
    rtc_req = 1'b1; rtc_slot = 3'd5; rtc_code = 4'd1;
    usr_req = 1'b1; usr_slot = 3'd5; usr_code = 4'd2; rd_slot = 3'd5;
    cyc_step();
    chk("t3b_usr_first", int'(usr_ack), 1);
    chk("t3b_rtc_wait", int'(rtc_ack), 0);
    cyc_step();
    chk("t3b_rtc_second", int'(rtc_ack), 1);
    do_commit();
    chk("t3b_slot5", int'(rd_code), 1);

    // Request raised together with the vblank edge is stalled through COMMIT/DONE
    cyc_step();
    vblank = 1'b1;
    usr_req = 1'b1; usr_slot = 3'd0; usr_code = 4'd5; rd_slot = 3'd0;
    for (int k = 0; k < 10; k++) begin
      cyc_step();
      if (k == 0) vblank = 1'b0;
      chk("t4_usr_ack_k", int'(usr_ack), (k == 8) ? 1 : 0);
    end
    chk("t4_not_yet", int'(rd_code), 0);
    do_commit();
    chk("t4_visible", int'(rd_code), 5);

    // Blink with BLINK_FRAMES=2 on slot 1
    do_reset();
    cursor_en = 1'b1; cursor_slot = 3'd1;
    for (int e = 1; e <= 4; e++) begin
      cyc_step();
      vblank = 1'b1;
      cyc_step();
      vblank = 1'b0;
      rd_slot = 3'd1;
      #1;
      chk("t5_blink_slot1", int'(rd_visible), ((e / 2) % 2 == 1) ? 0 : 1);
      rd_slot = 3'd0;
      #1;
      chk("t5_slot0_vis", int'(rd_visible), 1);
      repeat (8) cyc_step();
    end
    cursor_en = 1'b0; rd_slot = 3'd1;
    #1;
    chk("t5_cursor_off", int'(rd_visible), 1);

    // Out-of-range write
    cyc_step();
    usr_req = 1'b1; usr_slot = 3'd7; usr_code = 4'd15;
    cyc_step();
    chk("t6_err_ack", int'(usr_ack), 1);
    chk("t6_err_pulse", int'(err_slot), 1);
    cyc_step();
    chk("t6_err_once", int'(err_slot), 0);
    do_commit();

    // Reset in the middle of a commit
    rtc_req = 1'b1; rtc_slot = 3'd0; rtc_code = 4'd10;
    repeat (2) cyc_step();
    usr_req = 1'b1; usr_slot = 3'd5; usr_code = 4'd11;
    repeat (2) cyc_step();
    vblank = 1'b1;
    cyc_step();
    vblank = 1'b0;
    repeat (2) cyc_step();
    rd_slot = 3'd0;
    #1;
    chk("t7_slot0_committed", int'(rd_code), 10);
    rst_n = 1'b0;
    #1;
    chk("t7_reset_clears", int'(rd_code), 0);
    repeat (2) cyc_step();
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc_step();
      if (commit_done) done_seen = 1'b1;
    end
    chk("t7_no_commit_done", int'(done_seen), 0);
    do_commit();
    rd_slot = 3'd5;
    #1;
    chk("t7_pend_cleared", int'(rd_code), 0);

    // Random traffic against the model
    vb_hold = 5;
    for (int c = 0; c < 3000; c++) begin
      cyc_step();
      rst_n = ($urandom_range(0, 599) != 0);
      if (!rtc_req && $urandom_range(0, 2) == 0) begin
        rtc_req = 1'b1; rtc_slot = 3'($urandom_range(0, 7)); rtc_code = 4'($urandom);
      end
      if (!usr_req && $urandom_range(0, 2) == 0) begin
        usr_req = 1'b1; usr_slot = 3'($urandom_range(0, 7)); usr_code = 4'($urandom);
      end
      vb_hold--;
      if (vb_hold <= 0) begin
        vblank  = !vblank;
        vb_hold = vblank ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 15));
      end
      rd_slot = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) cursor_en = !cursor_en;
      if ($urandom_range(0, 99) == 0) cursor_slot = 3'($urandom_range(0, 7));
    end
    rst_n = 1'b1;
    repeat (3) cyc_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
